// File: rtl/jtframe_neptuno_joy_pkg.sv
// Shared types and frame-layout constants for the NeptUNO serial joystick front-end.
package jtframe_neptuno_joy_pkg;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_e;

    localparam int unsigned FRAME_LEN = 16;
    localparam logic [3:0]  J1_BASE   = 4'd0;
    localparam logic [3:0]  J2_BASE   = 4'd8;
    localparam int unsigned OFS_UP    = 0;
    localparam int unsigned OFS_DOWN  = 1;
    localparam int unsigned OFS_LEFT  = 2;
    localparam int unsigned OFS_RIGHT = 3;
    localparam int unsigned OFS_F1    = 4;
    localparam int unsigned OFS_F2    = 5;
    localparam int unsigned PAD_W     = OFS_F2 - OFS_UP + 1;

    // Six-bit {f2,f1,right,left,down,up} field of one player inside a frame.
    function automatic logic [PAD_W-1:0] pad_field(input logic [FRAME_LEN-1:0] frame,
                                                   input logic [3:0] base);
        return frame[base +: PAD_W];
    endfunction

endpackage

// File: rtl/jtframe_neptuno_joy_tick.sv
// CLKDIV-modulo divider: one-cycle o_tick on the terminal count, restarts on FSM state change.
module jtframe_neptuno_joy_tick #(
    parameter int CLKDIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [7:0] LAST = 8'(CLKDIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    // Divider count; a state change realigns it so every state gets a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_restart || o_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jtframe_neptuno_joy.sv
// NeptUNO 74HC165 joystick chain scanner; JTFRAME_NEPTUNO_JOY6_EN adds the select-low f3/f4 phase.
module jtframe_neptuno_joy
    import jtframe_neptuno_joy_pkg::*;
#(
    parameter int CLKDIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       joy_data_i,
    output logic       joy_clk_o,
    output logic       joy_load_o,
    output logic       joy_sel_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic       frame_o
);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [3:0]     r_bit;
    logic [FRAME_LEN-1:0] r_shift;
    logic           r_clk;
    logic           r_load;
    logic           r_sel;
    logic           r_frame;
    logic [7:0]     r_joy1;
    logic [7:0]     r_joy2;
    logic           w_tick;
    logic           w_restart;
    logic           w_latch;

    jtframe_neptuno_joy_tick #(.CLKDIV(CLKDIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_restart = (w_state_nxt != r_state);
    assign w_latch   = (w_state_nxt == ST_LATCH);

    // Next-state logic; LATCH is a single cycle regardless of the divider.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_tick) w_state_nxt = ST_SHIFT_LO;
                else        w_state_nxt = ST_LOAD;
            end
            ST_SHIFT_LO: begin
                if (w_tick) w_state_nxt = ST_SHIFT_HI;
                else        w_state_nxt = ST_SHIFT_LO;
            end
            ST_SHIFT_HI: begin
                if (w_tick && (r_bit == 4'(FRAME_LEN - 1))) w_state_nxt = ST_LATCH;
                else if (w_tick)                            w_state_nxt = ST_SHIFT_LO;
                else                                        w_state_nxt = ST_SHIFT_HI;
            end
            ST_LATCH:    w_state_nxt = ST_LOAD;
            default:     w_state_nxt = ST_LOAD;
        endcase
    end

    // State, bit counter, shift register and chain strobes (strobes follow the next state so they line up with it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_bit   <= 4'd0;
            r_shift <= 16'hFFFF;
            r_clk   <= 1'b0;
            r_load  <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clk   <= (w_state_nxt == ST_SHIFT_HI);
            r_load  <= (w_state_nxt != ST_LOAD);
            r_frame <= w_latch;
            if (r_state == ST_LOAD) begin
                r_bit <= 4'd0;
            end else if (r_state == ST_SHIFT_HI && w_tick) begin
                r_bit <= r_bit + 4'd1;
            end
            if (r_state == ST_SHIFT_LO && w_tick) begin
                r_shift[r_bit] <= joy_data_i;
            end
        end
    end

    // Player outputs move only on entry to LATCH, so a frame is always presented whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_joy1 <= 8'hFF;
            r_joy2 <= 8'hFF;
            r_sel  <= 1'b1;
        end else begin
`ifdef JTFRAME_NEPTUNO_JOY6_EN
            if (w_latch) begin
                if (r_sel) begin
                    r_joy1[5:0] <= pad_field(r_shift, J1_BASE);
                    r_joy2[5:0] <= pad_field(r_shift, J2_BASE);
                end else begin
                    r_joy1[7:6] <= {r_shift[J1_BASE + 4'(OFS_F2)], r_shift[J1_BASE + 4'(OFS_F1)]};
                    r_joy2[7:6] <= {r_shift[J2_BASE + 4'(OFS_F2)], r_shift[J2_BASE + 4'(OFS_F1)]};
                end
                r_sel <= ~r_sel;
            end
`else
            if (w_latch) begin
                r_joy1 <= {2'b11, pad_field(r_shift, J1_BASE)};
                r_joy2 <= {2'b11, pad_field(r_shift, J2_BASE)};
            end
            r_sel <= 1'b1;
`endif
        end
    end

    assign joy_clk_o  = r_clk;
    assign joy_load_o = r_load;
    assign joy_sel_o  = r_sel;
    assign joy1_o     = r_joy1;
    assign joy2_o     = r_joy2;
    assign frame_o    = r_frame;

endmodule
